// File: rtl/bcd_counter.sv
// bcd_counter: single-digit BCD counter, 0..MAX_DIGIT, with a terminal-count
// flag for ripple-carry chaining of digits.
//
// Build option: define BCD_COUNTER_SATURATE_EN to make the counter stop at
// MAX_DIGIT instead of wrapping; done then depends only on reset and Q.
// Without the macro the counter wraps to 0 and done is qualified by enable.
//
// reset is synchronous and active-low. done is intentionally combinational
// so the next digit in a chain sees the carry in the same cycle.
module bcd_counter #(
  parameter int MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       enable,
  input  logic       reset,
  output logic       done,
  output logic [3:0] Q
);

  // Terminal value at the width of the count register.
  localparam logic [3:0] MAX_Q = 4'(MAX_DIGIT);

  logic [3:0] q_r;
  logic [3:0] next_s;
  logic       at_max_s;
  logic       out_of_range_s;

  assign Q = q_r;

  // Decode terminal count and any illegal register contents.
  always_comb begin
    at_max_s       = 1'b0;
    out_of_range_s = 1'b0;
    if (q_r == MAX_Q) begin
      at_max_s = 1'b1;
    end else begin
      at_max_s = 1'b0;
    end
    if (q_r > MAX_Q) begin
      out_of_range_s = 1'b1;
    end else begin
      out_of_range_s = 1'b0;
    end
  end

  // Next-count selection: hold, increment, or wrap/saturate at the top.
  always_comb begin
    next_s = q_r;
    if (out_of_range_s) begin
      // A corrupted register recovers to a legal value instead of counting on.
      next_s = 4'd0;
    end else if (enable) begin
      if (at_max_s) begin
`ifdef BCD_COUNTER_SATURATE_EN
        next_s = MAX_Q;
`else
        next_s = 4'd0;
`endif
      end else begin
        next_s = q_r + 4'd1;
      end
    end else begin
      next_s = q_r;
    end
  end

  // Count register with synchronous active-low clear taking priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r <= 4'd0;
    end else begin
      q_r <= next_s;
    end
  end

  // Terminal-count flag; forced low while reset is asserted.
  always_comb begin
    done = 1'b0;
    if (!reset) begin
      done = 1'b0;
    end else begin
`ifdef BCD_COUNTER_SATURATE_EN
      done = at_max_s;
`else
      done = enable & at_max_s;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: a directed scenario with literal
// expectations, then randomized enable/reset traffic, all compared every
// cycle against an arithmetic reference model. Two instances run side by
// side: the default MAX_DIGIT=9 and MAX_DIGIT=5.
module tb_bcd_counter;

`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       enable;
  logic       reset;
  logic       done9;
  logic       done5;
  logic [3:0] q9;
  logic [3:0] q5;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m9 = 0;
  int m5 = 0;
  bit model_valid = 1'b0;

  bcd_counter u_dut9 (
    .clk    (clk),
    .enable (enable),
    .reset  (reset),
    .done   (done9),
    .Q      (q9)
  );

  bcd_counter #(.MAX_DIGIT(5)) u_dut5 (
    .clk    (clk),
    .enable (enable),
    .reset  (reset),
    .done   (done5),
    .Q      (q5)
  );

  // 40 ns clock period.
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Next value from the counting rules: modulo (max+1) or clamp at max.
  function automatic int model_next(input int m, input int max);
    if (SAT) return (m + 1 > max) ? max : m + 1;
    return (m + 1) % (max + 1);
  endfunction

  function automatic bit model_done(input int m, input int max);
    return reset && (m == max) && (SAT || enable);
  endfunction

  // Reference model advances on each rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      m9 <= 0;
      m5 <= 0;
      model_valid <= 1'b1;
    end else if (enable) begin
      m9 <= model_next(m9, 9);
      m5 <= model_next(m5, 5);
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model.
  task automatic compare_model();
    if (model_valid) begin
      check("q9_model", q9, 4'(m9));
      check("q5_model", q5, 4'(m5));
      check("done9_model", {3'd0, done9}, {3'd0, model_done(m9, 9)});
      check("done5_model", {3'd0, done5}, {3'd0, model_done(m5, 5)});
    end
  endtask

  // Advance one edge, then sample 5 ns later and compare against the model.
  task automatic tick();
    @(posedge clk);
    #5;
    compare_model();
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;

    // Reset phase: first 100 ns.
    repeat (3) tick();
    check("rst_q9", q9, 4'd0);
    check("rst_done9", {3'd0, done9}, 4'd0);
    check("rst_q5", q5, 4'd0);
    check("rst_done5", {3'd0, done5}, 4'd0);

    // Count to 5.
    reset  = 1'b1;
    enable = 1'b1;
    repeat (5) tick();
    check("cnt5_q9", q9, 4'd5);
    check("cnt5_done9", {3'd0, done9}, 4'd0);
    check("cnt5_q5", q5, 4'd5);
    check("cnt5_done5", {3'd0, done5}, 4'd1);

    // Hold for 3 edges with enable low.
    enable = 1'b0;
    repeat (3) tick();
    check("hold_q9", q9, 4'd5);
    check("hold_done9", {3'd0, done9}, 4'd0);
    check("hold_q5", q5, 4'd5);
    check("hold_done5", {3'd0, done5}, SAT ? 4'd1 : 4'd0);

    // Re-enable: one step.
    enable = 1'b1;
    tick();
    check("reen_q9", q9, 4'd6);
    check("reen_q5", q5, SAT ? 4'd5 : 4'd0);

    // Reach 7, then reset for one edge with enable still high.
    tick();
    check("q9_at7", q9, 4'd7);
    reset = 1'b0;
    tick();
    check("midrst_q9", q9, 4'd0);
    check("midrst_done9", {3'd0, done9}, 4'd0);
    check("midrst_q5", q5, 4'd0);
    check("midrst_done5", {3'd0, done5}, 4'd0);

    // Full run to the terminal value and past it.
    reset = 1'b1;
    repeat (9) tick();
    check("top_q9", q9, 4'd9);
    check("top_done9", {3'd0, done9}, 4'd1);
    tick();
    check("wrap_q9", q9, SAT ? 4'd9 : 4'd0);
    check("wrap_done9", {3'd0, done9}, SAT ? 4'd1 : 4'd0);
    enable = 1'b0;
    #1;
    check("dis_done9", {3'd0, done9}, SAT ? 4'd1 : 4'd0);

    // Randomized traffic: mostly enabled, occasional reset.
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(0, 99) < 80);
      reset  = ($urandom_range(0, 99) >= 4);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
